tmp_seq: RTL
============

TMP_SEQ -- requirements
Module: tmp_seq

Interface
REQ-001 SHALL take parameter NCH, default 4, number of sensor channels (1..16).
REQ-002 SHALL take parameter RES_W, default 10, result width in bits.
REQ-003 SHALL take parameter PRE_CYC, default 21, precharge duration in cycles (≥1).
REQ-004 SHALL take parameter SETTLE_CYC, default 21, first-diode settle duration in cycles (≥1).
REQ-005 SHALL take parameter PH_CYC, default 4, diode and big-diode phase duration in cycles (≥2).
REQ-006 SHALL take parameter CONV_LEN, default 256, samples per conversion (≥1).
REQ-007 SHALL have ports: clk input 1, system clock; reset_n input 1, asynchronous active-low reset.
REQ-008 SHALL have ports: en input 1, run request; cmp input 1, comparator decision; ready input 1, result accepted.
REQ-009 SHALL have ports: ch_sel output NCH, one-hot channel select; pre_chrg output 1; setup_bias output 1; phi_a output 1, diode phase; phi_b output 1, big-diode phase.
REQ-010 SHALL have ports: cmp_p1 output 1; cmp_p2 output 1; src_n output 1, active-low source pulse; snk output 1, sink pulse.
REQ-011 SHALL have ports: result output RES_W; res_ch output $clog2(NCH) (min 1); valid output 1.

Function
REQ-012 SHALL implement states IDLE, PRECHARGE, SETTLE, DIODE, BIGDIODE, OUTPUT; all outputs registered.
REQ-013 IDLE: all phase outputs low; leaves to PRECHARGE on the edge en=1 is sampled.
REQ-014 PRECHARGE: PRE_CYC cycles, pre_chrg=1, setup_bias=1, ch_sel one-hot on current channel, accumulator cleared.
REQ-015 SETTLE: SETTLE_CYC cycles, phi_a=1, setup_bias=1; then DIODE with setup_bias=0.
REQ-016 One sample = DIODE (phi_a=1, PH_CYC cycles) then BIGDIODE (phi_b=1, PH_CYC cycles); phi_a and phi_b never high together.
REQ-017 cmp_p1 and cmp_p2 SHALL both invert on the first cycle of every DIODE phase; they are always complementary.
REQ-018 On the last BIGDIODE cycle cmp SHALL be sampled: accumulator += cmp, saturating at 2^RES_W-1.
REQ-019 In the cycle following each sample edge, exactly one of src_n=0 (cmp was 1) or snk=1 (cmp was 0) SHALL be asserted for exactly one cycle, including after the last sample.
REQ-020 After CONV_LEN samples go to OUTPUT: valid=1, result=accumulator, res_ch=current channel; phase outputs low.
REQ-021 valid/result/res_ch SHALL hold stable while ready=0; transfer occurs on the edge with valid=1 and ready=1.
REQ-022 On transfer: channel index advances, NCH-1 wraps to 0; next state PRECHARGE if en=1, else IDLE; valid drops the next cycle.
REQ-023 en=0 mid-conversion SHALL not abort; the conversion completes and IDLE follows transfer.
REQ-024 valid SHALL first rise PRE_CYC+SETTLE_CYC+2*PH_CYC*CONV_LEN+1 cycles after en is sampled in IDLE.

Reset
REQ-025 reset_n=0 SHALL immediately force: state IDLE, channel 0, ch_sel=0, pre_chrg=0, setup_bias=0, phi_a=0, phi_b=0, cmp_p1=0, cmp_p2=1, src_n=1, snk=0, valid=0, result=0, res_ch=0, counters 0.
REQ-026 Reset mid-conversion SHALL discard the conversion; no partial result is ever presented.

Configuration
REQ-027 With TMP_SEQ_CHOP_EN defined, each conversion SHALL run 2*CONV_LEN samples, the second half with phi_a/phi_b roles swapped, and the accumulator spans both halves.
REQ-028 Without TMP_SEQ_CHOP_EN, REQ-016..REQ-024 apply unchanged and no swap logic exists.

Structure
REQ-029 Package tmp_seq_pkg SHALL hold the state enum and default parameter constants.
REQ-030 Sub-module tmp_seq_phase_cnt SHALL provide the load/terminal-count duration counter shared by all timed states.

Verification
REQ-031 cmp=1 constant, defaults -> result=256, 256 src_n pulses, 0 snk pulses, valid at cycle 2091.
REQ-032 cmp=0 constant -> result=0, 256 snk pulses; cmp alternating per sample -> result=128.
REQ-033 RES_W=6, cmp=1 -> result saturates at 63.
REQ-034 en held, ready=1 -> ch_sel 0001,0010,0100,1000,0001, res_ch 0,1,2,3,0; ready=0 for 10 cycles -> valid and result stable.
REQ-035 reset_n low during sample 100 -> all REQ-025 values same cycle; restart yields a full fresh conversion.
REQ-036 TMP_SEQ_CHOP_EN, cmp=1 -> result=512, phi_b leads phi_a in second half.

Source files
------------

// File: rtl/tmp_seq_pkg.sv
// Shared state encoding, default timing constants and width helper for the
// temperature-sensor conversion sequencer.
package tmp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECHARGE,
    ST_SETTLE,
    ST_DIODE,
    ST_BIGDIODE,
    ST_OUTPUT
  } state_t;

  localparam int DEF_NCH        = 4;
  localparam int DEF_RES_W      = 10;
  localparam int DEF_PRE_CYC    = 21;
  localparam int DEF_SETTLE_CYC = 21;
  localparam int DEF_PH_CYC     = 4;
  localparam int DEF_CONV_LEN   = 256;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tmp_seq_phase_cnt.sv
// Down-counter timing every timed state: load (duration-1) on state entry,
// o_tc flags the final cycle of that state; holds at zero otherwise.
module tmp_seq_phase_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/tmp_seq.sv
// Diode temperature-sensor sequencer: valid rises PRE+SETTLE+2*PH*samples+1 cycles after start,
// result held until ready; TMP_SEQ_CHOP_EN doubles samples, swapping phi_a/phi_b in the second half.
module tmp_seq
  import tmp_seq_pkg::*;
#(
  parameter int NCH        = DEF_NCH,
  parameter int RES_W      = DEF_RES_W,
  parameter int PRE_CYC    = DEF_PRE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int PH_CYC     = DEF_PH_CYC,
  parameter int CONV_LEN   = DEF_CONV_LEN
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic                        cmp,
  input  logic                        ready,
  output logic [NCH-1:0]              ch_sel,
  output logic                        pre_chrg,
  output logic                        setup_bias,
  output logic                        phi_a,
  output logic                        phi_b,
  output logic                        cmp_p1,
  output logic                        cmp_p2,
  output logic                        src_n,
  output logic                        snk,
  output logic [RES_W-1:0]            result,
  output logic [clog2_min1(NCH)-1:0]  res_ch,
  output logic                        valid
);

  localparam int CH_W = clog2_min1(NCH);
`ifdef TMP_SEQ_CHOP_EN
  localparam int NSMP = 2 * CONV_LEN;
`else
  localparam int NSMP = CONV_LEN;
`endif
  localparam int SMP_W = $clog2(NSMP + 1);
  localparam int DMAX  = (PRE_CYC > SETTLE_CYC) ?
                         ((PRE_CYC > PH_CYC) ? PRE_CYC : PH_CYC) :
                         ((SETTLE_CYC > PH_CYC) ? SETTLE_CYC : PH_CYC);
  localparam int CNT_W = clog2_min1(DMAX);
  localparam logic [RES_W-1:0] ACC_MAX = {RES_W{1'b1}};

  state_t             r_state, w_state_nxt;
  logic [CH_W-1:0]    r_ch, w_ch_nxt;
  logic [SMP_W-1:0]   r_smp, w_smp_nxt;
  logic [RES_W-1:0]   r_acc, w_acc_nxt;
  logic               w_load, w_tc, w_sample;
  logic [CNT_W-1:0]   w_load_val;

  logic [NCH-1:0]     r_ch_sel, w_ch_sel_nxt;
  logic               r_pre_chrg, w_pre_chrg_nxt;
  logic               r_setup_bias, w_setup_bias_nxt;
  logic               r_phi_a, w_phi_a_nxt;
  logic               r_phi_b, w_phi_b_nxt;
  logic               r_cmp_p1, w_cmp_p1_nxt;
  logic               r_cmp_p2;
  logic               r_src_n, r_snk;
  logic [RES_W-1:0]   r_result, w_result_nxt;
  logic [CH_W-1:0]    r_res_ch, w_res_ch_nxt;
  logic               r_valid, w_valid_nxt;
`ifdef TMP_SEQ_CHOP_EN
  logic               w_swap;
`endif

  tmp_seq_phase_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_ch_nxt     = r_ch;
    w_smp_nxt    = r_smp;
    w_acc_nxt    = r_acc;
    w_sample     = 1'b0;
    w_valid_nxt  = r_valid;
    w_result_nxt = r_result;
    w_res_ch_nxt = r_res_ch;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = ST_PRECHARGE;
          w_load      = 1'b1;
          w_load_val  = CNT_W'(PRE_CYC - 1);
        end
      end
      ST_PRECHARGE: begin
        if (w_tc) begin
          w_state_nxt = ST_SETTLE;
          w_load      = 1'b1;
          w_load_val  = CNT_W'(SETTLE_CYC - 1);
        end
      end
      ST_SETTLE: begin
        if (w_tc) begin
          w_state_nxt = ST_DIODE;
          w_load      = 1'b1;
          w_load_val  = CNT_W'(PH_CYC - 1);
        end
      end
      ST_DIODE: begin
        if (w_tc) begin
          w_state_nxt = ST_BIGDIODE;
          w_load      = 1'b1;
          w_load_val  = CNT_W'(PH_CYC - 1);
        end
      end
      ST_BIGDIODE: begin
        if (w_tc) begin
          w_sample  = 1'b1;
          w_smp_nxt = r_smp + 1'b1;
          if (cmp && (r_acc != ACC_MAX)) begin
            w_acc_nxt = r_acc + 1'b1;
          end
          if (r_smp == SMP_W'(NSMP - 1)) begin
            w_state_nxt = ST_OUTPUT;
          end else begin
            w_state_nxt = ST_DIODE;
            w_load      = 1'b1;
            w_load_val  = CNT_W'(PH_CYC - 1);
          end
        end
      end
      ST_OUTPUT: begin
        // First OUTPUT cycle captures the final accumulator; handshake starts after.
        if (!r_valid) begin
          w_valid_nxt  = 1'b1;
          w_result_nxt = r_acc;
          w_res_ch_nxt = r_ch;
        end else if (ready) begin
          w_valid_nxt = 1'b0;
          w_ch_nxt    = (r_ch == CH_W'(NCH - 1)) ? '0 : r_ch + 1'b1;
          if (en) begin
            w_state_nxt = ST_PRECHARGE;
            w_load      = 1'b1;
            w_load_val  = CNT_W'(PRE_CYC - 1);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt == ST_PRECHARGE) begin
      w_acc_nxt = '0;
      w_smp_nxt = '0;
    end
  end

  // Phase outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    w_ch_sel_nxt     = '0;
    w_pre_chrg_nxt   = 1'b0;
    w_setup_bias_nxt = 1'b0;
    w_phi_a_nxt      = 1'b0;
    w_phi_b_nxt      = 1'b0;
`ifdef TMP_SEQ_CHOP_EN
    w_swap           = (w_smp_nxt >= SMP_W'(CONV_LEN));
`endif
    case (w_state_nxt)
      ST_PRECHARGE: begin
        w_ch_sel_nxt     = NCH'(1) << w_ch_nxt;
        w_pre_chrg_nxt   = 1'b1;
        w_setup_bias_nxt = 1'b1;
      end
      ST_SETTLE: begin
        w_ch_sel_nxt     = NCH'(1) << w_ch_nxt;
        w_phi_a_nxt      = 1'b1;
        w_setup_bias_nxt = 1'b1;
      end
      ST_DIODE: begin
        w_ch_sel_nxt = NCH'(1) << w_ch_nxt;
`ifdef TMP_SEQ_CHOP_EN
        w_phi_a_nxt  = !w_swap;
        w_phi_b_nxt  = w_swap;
`else
        w_phi_a_nxt  = 1'b1;
`endif
      end
      ST_BIGDIODE: begin
        w_ch_sel_nxt = NCH'(1) << w_ch_nxt;
`ifdef TMP_SEQ_CHOP_EN
        w_phi_a_nxt  = w_swap;
        w_phi_b_nxt  = !w_swap;
`else
        w_phi_b_nxt  = 1'b1;
`endif
      end
      default: ;
    endcase
    w_cmp_p1_nxt = r_cmp_p1;
    if ((w_state_nxt == ST_DIODE) && (r_state != ST_DIODE)) begin
      w_cmp_p1_nxt = !r_cmp_p1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch         <= '0;
      r_smp        <= '0;
      r_acc        <= '0;
      r_ch_sel     <= '0;
      r_pre_chrg   <= 1'b0;
      r_setup_bias <= 1'b0;
      r_phi_a      <= 1'b0;
      r_phi_b      <= 1'b0;
      r_cmp_p1     <= 1'b0;
      r_cmp_p2     <= 1'b1;
      r_src_n      <= 1'b1;
      r_snk        <= 1'b0;
      r_result     <= '0;
      r_res_ch     <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_ch         <= w_ch_nxt;
      r_smp        <= w_smp_nxt;
      r_acc        <= w_acc_nxt;
      r_ch_sel     <= w_ch_sel_nxt;
      r_pre_chrg   <= w_pre_chrg_nxt;
      r_setup_bias <= w_setup_bias_nxt;
      r_phi_a      <= w_phi_a_nxt;
      r_phi_b      <= w_phi_b_nxt;
      r_cmp_p1     <= w_cmp_p1_nxt;
      r_cmp_p2     <= !w_cmp_p1_nxt;
      r_src_n      <= !(w_sample && cmp);
      r_snk        <= w_sample && !cmp;
      r_result     <= w_result_nxt;
      r_res_ch     <= w_res_ch_nxt;
      r_valid      <= w_valid_nxt;
    end
  end

  assign ch_sel     = r_ch_sel;
  assign pre_chrg   = r_pre_chrg;
  assign setup_bias = r_setup_bias;
  assign phi_a      = r_phi_a;
  assign phi_b      = r_phi_b;
  assign cmp_p1     = r_cmp_p1;
  assign cmp_p2     = r_cmp_p2;
  assign src_n      = r_src_n;
  assign snk        = r_snk;
  assign result     = r_result;
  assign res_ch     = r_res_ch;
  assign valid      = r_valid;

endmodule
